// File: rtl/board_render_ctrl.sv
// Board RAM arbiter, hblank line-buffer prefetch and per-pixel color index for the Tetris board.
// Optional build macro GRID_LINES_EN draws 4'hc grid lines on the empty cells.
module board_render_ctrl #(
  parameter int BOARD_X0 = 240,
  parameter int BOARD_Y0 = 80,
  parameter int BORDER_W = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       game_req,
  input  logic       game_we,
  input  logic [7:0] game_addr,
  input  logic [3:0] game_wdata,
  output logic       game_ack,
  output logic [3:0] game_rdata,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [3:0] ram_wdata,
  input  logic [3:0] ram_rdata,
  output logic [3:0] color,
  output logic       fetching
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  localparam logic signed [10:0] L_X0  = 11'(BOARD_X0);
  localparam logic signed [10:0] L_Y0  = 11'(BOARD_Y0);
  localparam logic signed [10:0] L_BDR = 11'(BORDER_W);
  localparam logic signed [10:0] L_W   = 11'sd160;
  localparam logic signed [10:0] L_H   = 11'sd320;

  state_t      r_state;
  logic        r_fetching;
  logic [3:0]  r_col;
  logic [7:0]  r_fetch_addr;
  logic        r_cap_en;
  logic [3:0]  r_cap_idx;
  logic        r_prev_640;
  logic [3:0]  r_linebuf [0:9];
  logic        r_rd_pending;
  logic [3:0]  r_game_rdata;
  logic [3:0]  r_color;

  logic               w_at_640;
  logic               w_edge;
  logic [9:0]         w_next_y;
  logic signed [10:0] w_ny_rel;
  logic               w_ny_in;
  logic [4:0]         w_fetch_row;
  logic [7:0]         w_row_base;
  logic               w_start;
  logic               w_grant;
  logic               w_oob;

  // One fetch per line: only the rising edge of DrawX==640 counts.
  assign w_at_640    = (DrawX == 10'd640);
  assign w_edge      = w_at_640 & ~r_prev_640;
  assign w_next_y    = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
  assign w_ny_rel    = $signed({1'b0, w_next_y}) - L_Y0;
  assign w_ny_in     = (w_ny_rel >= 11'sd0) && (w_ny_rel < L_H);
  assign w_fetch_row = w_ny_rel[8:4];
  assign w_row_base  = {w_fetch_row, 3'b000} + {2'b00, w_fetch_row, 1'b0};

  assign w_start = (r_state == S_IDLE) && w_edge && w_ny_in;
  assign w_grant = (r_state == S_IDLE) && !w_start && game_req;
  assign w_oob   = (game_addr >= 8'd200);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_fetching   <= 1'b0;
      r_col        <= 4'd0;
      r_fetch_addr <= 8'd0;
      r_cap_en     <= 1'b0;
      r_cap_idx    <= 4'd0;
    end else begin
      // NOTE: non-blocking everywhere in clocked blocks so every register samples pre-edge values.
      r_cap_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state      <= S_FETCH;
            r_fetching   <= 1'b1;
            r_col        <= 4'd0;
            r_fetch_addr <= w_row_base;
          end
        end
        S_FETCH: begin
          r_cap_en  <= 1'b1;
          r_cap_idx <= r_col;
          if (r_col == 4'd9) begin
            r_state    <= S_DRAIN;
            r_fetching <= 1'b0;
          end else begin
            r_col        <= r_col + 4'd1;
            r_fetch_addr <= r_fetch_addr + 8'd1;
          end
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Grant is decided and presented in the same cycle so a held request is never granted twice.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    ram_addr  = 8'd0;
    ram_we    = 1'b0;
    ram_wdata = 4'h0;
    game_ack  = 1'b0;
    if (r_state == S_FETCH) begin
      ram_addr = r_fetch_addr;
    end else if (w_grant) begin
      ram_addr  = game_addr;
      ram_we    = game_we & ~w_oob;
      ram_wdata = game_wdata;
      game_ack  = 1'b1;
    end
  end

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic               w_visible;
  logic               w_in_board;
  logic               w_in_outer;
  logic [3:0]         w_cell;
  logic [3:0]         w_cell_val;
  logic [3:0]         w_color;

  assign w_dx       = $signed({1'b0, DrawX}) - L_X0;
  assign w_dy       = $signed({1'b0, DrawY}) - L_Y0;
  assign w_visible  = (DrawX < 10'd640) && (DrawY < 10'd480);
  assign w_in_board = (w_dx >= 11'sd0) && (w_dx < L_W) && (w_dy >= 11'sd0) && (w_dy < L_H);
  assign w_in_outer = (w_dx >= -L_BDR) && (w_dx < L_W + L_BDR) &&
                      (w_dy >= -L_BDR) && (w_dy < L_H + L_BDR);
  assign w_cell     = w_dx[7:4];
  assign w_cell_val = (w_cell < 4'd10) ? r_linebuf[w_cell] : 4'h0;

  always_comb begin
    w_color = 4'hf;
    if (w_visible) begin
      if (w_in_board) begin
        if (w_cell_val != 4'h0) begin
          w_color = w_cell_val;
        end else begin
          w_color = 4'h0;
`ifdef GRID_LINES_EN
          if ((w_dx[3:0] == 4'd0) || (w_dy[3:0] == 4'd0)) w_color = 4'hc;
`endif
        end
      end else if (w_in_outer) begin
        w_color = 4'hd;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_prev_640   <= 1'b0;
      r_rd_pending <= 1'b0;
      r_game_rdata <= 4'h0;
      r_color      <= 4'hf;
      // NOTE: the line buffer is reset on purpose: a reset mid-fetch must not leave a half row on screen.
      for (int i = 0; i < 10; i++) r_linebuf[i] <= 4'h0;
    end else begin
      r_prev_640   <= w_at_640;
      r_rd_pending <= w_grant & ~game_we & ~w_oob;
      if (r_cap_en) r_linebuf[r_cap_idx] <= ram_rdata;
      if (w_grant && w_oob) r_game_rdata <= 4'h0;
      else if (r_rd_pending) r_game_rdata <= ram_rdata;
      r_color <= w_color;
    end
  end

  // Read data is forwarded in the cycle it arrives, then held by the register.
  assign game_rdata = r_rd_pending ? ram_rdata : r_game_rdata;
  assign color      = r_color;
  assign fetching   = r_fetching;

endmodule

// File: tb/tb_board_render_ctrl.sv
// Self-checking bench for board_render_ctrl: pixel table, directed fetch/arbitration/reset
// sequences and randomized traffic against a cell-level reference model.
module tb_board_render_ctrl;

  localparam int X0 = 240;
  localparam int Y0 = 80;
  localparam int BW = 4;
`ifdef GRID_LINES_EN
  localparam logic [3:0] GRID_C = 4'hc;
`else
  localparam logic [3:0] GRID_C = 4'h0;
`endif

  logic       Clk;
  logic       Reset;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       game_req;
  logic       game_we;
  logic [7:0] game_addr;
  logic [3:0] game_wdata;
  logic       game_ack;
  logic [3:0] game_rdata;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic [3:0] color;
  logic       fetching;

  board_render_ctrl #(.BOARD_X0(X0), .BOARD_Y0(Y0), .BORDER_W(BW)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr), .game_wdata(game_wdata),
    .game_ack(game_ack), .game_rdata(game_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .color(color), .fetching(fetching)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Board RAM: single port, read-first, 1-cycle read latency.
  logic [3:0] mem [0:255] = '{default: 4'h0};
  always @(posedge Clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int fetch_q[$];
  int we_cnt = 0;
  int we_bad = 0;
  always @(negedge Clk) begin
    if (fetching) fetch_q.push_back(int'(ram_addr));
    if (ram_we) begin
      we_cnt++;
      if (fetching) we_bad++;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: cell contents and the row last copied into the line buffer.
  logic [3:0] ref_mem [0:199];
  logic [3:0] ref_lb  [0:9];

  function automatic logic [3:0] exp_color(input int x, input int y);
    int dx = x - X0;
    int dy = y - Y0;
    logic [3:0] c;
    if (x >= 640 || y >= 480) return 4'hf;
    if (dx >= 0 && dx < 160 && dy >= 0 && dy < 320) begin
      c = ref_lb[dx / 16];
      if (c != 4'h0) return c;
      if ((dx % 16 == 0) || (dy % 16 == 0)) return GRID_C;
      return 4'h0;
    end
    if (dx >= -BW && dx < 160 + BW && dy >= -BW && dy < 320 + BW) return 4'hd;
    return 4'hf;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [3:0] exp, input string name);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    check(name, color, exp);
  endtask

  // Holds the request until ack; returns cycles waited and read data from the cycle after ack.
  task automatic game_op(input logic we, input int addr, input logic [3:0] wd, input logic trig,
                         output int waited, output logic [3:0] rd);
    game_req   = 1'b1;
    game_we    = we;
    game_addr  = 8'(addr);
    game_wdata = wd;
    if (trig) DrawX = 10'd640;
    waited = 0;
    #1;
    while (!game_ack && waited < 40) begin
      @(posedge Clk);
      #1;
      waited++;
    end
    if (!game_ack) check("ack_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    #1;
    game_req = 1'b0;
    game_we  = 1'b0;
    rd = game_rdata;
  endtask

  task automatic game_checked(input logic we, input int addr, input logic [3:0] wd);
    int waited;
    logic [3:0] rd;
    game_op(we, addr, wd, 1'b0, waited, rd);
    check("game_wait_idle", waited, 0);
    if (we) begin
      if (addr < 200) ref_mem[addr] = wd;
    end else begin
      check("game_rdata", rd, (addr < 200) ? ref_mem[addr] : 4'h0);
    end
  endtask

  task automatic do_fetch(input int y);
    int row;
    DrawY = 10'(y);
    DrawX = 10'd639;
    tick();
    DrawX = 10'd640;
    repeat (14) tick();
    DrawX = 10'd641;
    row = (y + 1 - Y0) / 16;
    for (int c = 0; c < 10; c++) ref_lb[c] = ref_mem[row * 10 + c];
  endtask

  typedef struct {
    int         x;
    int         y;
    logic [3:0] exp;
  } pix_vec_t;

  pix_vec_t   vt [16];
  logic [3:0] vals [0:9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    int guard;
    int we_before;
    int r;
    int x;
    int y;
    logic [3:0] rd;

    for (int i = 0; i < 200; i++) ref_mem[i] = 4'h0;
    for (int i = 0; i < 10; i++) ref_lb[i] = 4'h0;
    for (int i = 0; i < 10; i++) vals[i] = (i < 9) ? 4'(i + 1) : 4'he;

    Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
    game_req = 1'b0; game_we = 1'b0; game_addr = 8'd0; game_wdata = 4'h0;
    repeat (3) tick();
    check("rst_color", color, 4'hf);
    check("rst_ack", game_ack, 1'b0);
    check("rst_rdata", game_rdata, 4'h0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 8'd0);
    check("rst_fetching", fetching, 1'b0);
    Reset = 1'b0;
    tick();

    // Pixel regions with an empty line buffer.
    vt[0]  = '{0, 0, 4'hf};
    vt[1]  = '{X0 - 1, Y0, 4'hd};
    vt[2]  = '{X0 - BW - 1, Y0, 4'hf};
    vt[3]  = '{X0 - BW, Y0, 4'hd};
    vt[4]  = '{X0 + 5, Y0 + 5, 4'h0};
    vt[5]  = '{X0, Y0 + 3, GRID_C};
    vt[6]  = '{X0 + 3, Y0 + 16, GRID_C};
    vt[7]  = '{X0 + 159, Y0 + 319, 4'h0};
    vt[8]  = '{X0 + 160, Y0, 4'hd};
    vt[9]  = '{X0 + 163, Y0 + 7, 4'hd};
    vt[10] = '{X0 + 164, Y0 + 7, 4'hf};
    vt[11] = '{X0 + 7, Y0 - 4, 4'hd};
    vt[12] = '{X0 + 7, Y0 - 5, 4'hf};
    vt[13] = '{X0 + 7, Y0 + 323, 4'hd};
    vt[14] = '{X0 + 7, Y0 + 324, 4'hf};
    vt[15] = '{700, 100, 4'hf};
    for (int i = 0; i < 16; i++) pix(vt[i].x, vt[i].y, vt[i].exp, $sformatf("pix_table_%0d", i));

    // Preload row 0 and fetch it during the line above the board.
    for (int c = 0; c < 10; c++) game_checked(1'b1, c, vals[c]);
    fetch_q.delete();
    do_fetch(Y0 - 1);
    check("fetch_len", fetch_q.size(), 10);
    for (int i = 0; i < 10 && i < fetch_q.size(); i++) check($sformatf("fetch_addr_%0d", i), fetch_q[i], i);
    for (int k = 0; k < 10; k++) pix(X0 + 16 * k, Y0, vals[k], $sformatf("row0_col_%0d", k));

    // Reset while column 5 is being read.
    fetch_q.delete();
    DrawY = 10'(Y0 - 1);
    DrawX = 10'd639;
    tick();
    DrawX = 10'd640;
    guard = 0;
    while (fetch_q.size() < 6 && guard < 30) begin
      @(negedge Clk);
      #1;
      guard++;
    end
    check("rst_reach_col5", fetch_q.size(), 6);
    Reset = 1'b1;
    DrawX = 10'd641;
    #1;
    check("midrst_fetching", fetching, 1'b0);
    check("midrst_color", color, 4'hf);
    tick();
    tick();
    Reset = 1'b0;
    repeat (14) tick();
    check("midrst_no_refetch", fetch_q.size(), 6);
    for (int i = 0; i < 10; i++) ref_lb[i] = 4'h0;
    for (int k = 0; k < 10; k++)
      pix(X0 + 16 * k + 5, Y0 + 5, exp_color(X0 + 16 * k + 5, Y0 + 5), $sformatf("midrst_lb_%0d", k));
    do_fetch(Y0 - 1);
    pix(X0 + 16 * 9 + 2, Y0 + 2, 4'he, "refetch_col9");

    // Game boundary addresses.
    game_checked(1'b1, 199, 4'h7);
    game_checked(1'b0, 199, 4'h0);
    we_before = we_cnt;
    game_op(1'b1, 200, 4'h9, 1'b0, waited, rd);
    check("oob_wait", waited, 0);
    check("oob_rdata", rd, 4'h0);
    check("oob_no_we", we_cnt - we_before, 0);
    check("oob_mem", mem[200], 4'h0);

    // Game write raised in the trigger cycle waits out the whole fetch.
    DrawY = 10'(Y0 + 50);
    DrawX = 10'd639;
    tick();
    we_before = we_cnt;
    game_op(1'b1, 37, 4'h5, 1'b1, waited, rd);
    DrawX = 10'd641;
    check("contend_wait", waited, 12);
    check("contend_we_cycles", we_cnt - we_before, 1);
    for (int c = 0; c < 10; c++) ref_lb[c] = ref_mem[30 + c];
    ref_mem[37] = 4'h5;
    game_checked(1'b0, 37, 4'h0);
    pix(X0 + 16 * 7 + 5, Y0 + 5, exp_color(X0 + 16 * 7 + 5, Y0 + 5), "contend_lb_col7");

    // Trigger rows at the edges of the board.
    fetch_q.delete();
    DrawY = 10'd524; DrawX = 10'd639; tick();
    DrawX = 10'd640; repeat (14) tick(); DrawX = 10'd641;
    check("no_fetch_y524", fetch_q.size(), 0);
    DrawY = 10'(Y0 + 319); DrawX = 10'd639; tick();
    DrawX = 10'd640; repeat (14) tick(); DrawX = 10'd641;
    check("no_fetch_below", fetch_q.size(), 0);
    do_fetch(Y0 + 318);
    check("last_row_len", fetch_q.size(), 10);
    if (fetch_q.size() > 0) check("last_row_addr0", fetch_q[0], 190);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        game_checked(1'($urandom_range(0, 1)), $urandom_range(0, 219), 4'($urandom_range(0, 15)));
      end else if (r < 7) begin
        do_fetch(Y0 - 1 + 16 * $urandom_range(0, 19) + $urandom_range(0, 15));
      end else begin
        for (int j = 0; j < 3; j++) begin
          x = $urandom_range(0, 799);
          if (x == 640) x = 641;
          y = $urandom_range(0, 524);
          pix(x, y, exp_color(x, y), "rand_pix");
        end
      end
    end

    check("we_during_fetch", we_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
